// File: rtl/note_glyph_reader.sv
// Reads one row of font-ROM glyph bytes per character of a latched note word,
// assembles a full pixel row and emits it, repeating for all 8 glyph rows.
module note_glyph_reader #(
   parameter int NUM_CHARS  = 5,
   parameter int GLYPH_ROWS = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [9*NUM_CHARS-1:0]   note_addr,
   output logic [8:0]               rom_addr,
   input  logic [7:0]               rom_data,
   output logic [8*NUM_CHARS-1:0]   row_data,
   output logic [2:0]               row_idx,
   output logic                     row_valid,
   output logic                     busy,
   output logic                     done
);

   localparam int CW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam logic [CW-1:0] LastChar = CW'(NUM_CHARS - 1);
   localparam logic [2:0]    LastRow  = 3'(GLYPH_ROWS - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      LAST,
      EMIT
   } state_t;

   state_t r_state;
   state_t w_nextState;

   logic [9*NUM_CHARS-1:0] r_word;
   logic [8*NUM_CHARS-1:0] r_asm;
   logic [CW-1:0]          r_char;
   logic [2:0]             r_row;
   logic [8:0]             w_field;
   logic [8*NUM_CHARS-1:0] w_rowNext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_field = '0;
      for (int k = 0; k < NUM_CHARS; k++) begin
         if (r_char == CW'(k)) begin
            w_field = r_word[9*(NUM_CHARS-1-k) +: 9];
         end
      end
   end

   // The last character's byte is still on rom_data when LAST hands the row over.
   always_comb begin
      w_rowNext = r_asm | (8*NUM_CHARS)'(rom_data);
   end

   always_comb begin
      w_nextState = r_state;
      rom_addr    = '0;
      row_valid   = 1'b0;
      done        = 1'b0;
      busy        = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = ISSUE;
            end
         end
         ISSUE: begin
            rom_addr = (w_field & 9'h1F8) | {6'b0, r_row};
            if (r_char == LastChar) begin
               w_nextState = LAST;
            end
         end
         LAST: begin
            w_nextState = EMIT;
         end
         EMIT: begin
            row_valid = 1'b1;
            if (r_row == LastRow) begin
               done        = 1'b1;
               w_nextState = IDLE;
            end else begin
               w_nextState = ISSUE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word   <= '0;
         r_asm    <= '0;
         r_char   <= '0;
         r_row    <= '0;
         row_data <= '0;
         row_idx  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_word <= note_addr;
                  r_char <= '0;
                  r_row  <= '0;
               end
            end
            ISSUE: begin
               if (r_char != LastChar) begin
                  r_char <= r_char + 1'b1;
               end
               // ROM answers one cycle late, so this cycle's data belongs to char r_char-1.
               for (int k = 0; k < NUM_CHARS - 1; k++) begin
                  if (r_char == CW'(k + 1)) begin
                     r_asm[8*(NUM_CHARS-1-k) +: 8] <= rom_data;
                  end
               end
            end
            LAST: begin
               row_data <= w_rowNext;
               row_idx  <= r_row;
            end
            EMIT: begin
               if (r_row != LastRow) begin
                  r_row  <= r_row + 1'b1;
                  r_char <= '0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_note_glyph_reader.sv
// Directed bench for note_glyph_reader with a registered font-ROM model that
// returns the low 8 address bits as glyph data.
module tb_note_glyph_reader;

   localparam int N = 5;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [9*N-1:0] note_addr;
   logic [8:0]    rom_addr;
   logic [7:0]    rom_data;
   logic [8*N-1:0] row_data;
   logic [2:0]    row_idx;
   logic          row_valid;
   logic          busy;
   logic          done;

   int errors = 0;
   int checks = 0;

   logic [8*N-1:0] rowSnap [8];
   logic [8:0]     addrSnap [8];

   localparam logic [9*N-1:0] WordA = {9'd144, 9'd40, 9'd152, 9'd160, 9'd256};
   localparam logic [9*N-1:0] WordB = {9'd8, 9'd16, 9'd24, 9'd32, 9'd48};
   localparam logic [9*N-1:0] WordD = {9'h18F, 9'h008, 9'h010, 9'h018, 9'h100};

   note_glyph_reader #(.NUM_CHARS(N), .GLYPH_ROWS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .note_addr (note_addr),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .row_data  (row_data),
      .row_idx   (row_idx),
      .row_valid (row_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Synchronous font ROM stand-in
   always @(posedge clk) rom_data <= rom_addr[7:0];

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".rom_addr"}, 64'(rom_addr), 64'd0);
      checkOutput({tag, ".row_data"}, 64'(row_data), 64'd0);
      checkOutput({tag, ".row_idx"}, 64'(row_idx), 64'd0);
      checkOutput({tag, ".row_valid"}, 64'(row_valid), 64'd0);
      checkOutput({tag, ".done"}, 64'(done), 64'd0);
      checkOutput({tag, ".busy"}, 64'(busy), 64'd0);
   endtask

   function automatic logic [8:0] fieldOf(input logic [9*N-1:0] w, input int k);
      return w[9*(N-1-k) +: 9];
   endfunction

   // Renders one word and checks every cycle 1..56 after the accepting edge.
   task automatic applyStimulus(input logic [9*N-1:0] word, input bit holdStart);
      int r;
      int p;
      logic [2:0]     r3;
      logic [8:0]     fld;
      logic [8:0]     expAddr;
      logic [8*N-1:0] expRow;
      @(negedge clk);
      start     = 1'b1;
      note_addr = word;
      for (int c = 1; c <= 56; c++) begin
         @(negedge clk);
         if (holdStart) note_addr = (9*N)'({$urandom(), $urandom()});
         else start = 1'b0;
         r  = (c - 1) / 7;
         p  = (c - 1) % 7;
         r3 = 3'(r);
         if (p < N) begin
            fld     = fieldOf(word, p);
            expAddr = {fld[8:3], r3};
         end else begin
            expAddr = 9'd0;
         end
         checkOutput("rom_addr", 64'(rom_addr), 64'(expAddr));
         checkOutput("busy", 64'(busy), 64'd1);
         checkOutput("row_valid", 64'(row_valid), 64'(p == 6));
         checkOutput("done", 64'(done), 64'(p == 6 && r == 7));
         if (p == 0) addrSnap[r] = rom_addr;
         if (p == 6) begin
            expRow = '0;
            for (int k = 0; k < N; k++) begin
               fld = fieldOf(word, k);
               expRow[8*(N-1-k) +: 8] = {fld[7:3], r3};
            end
            checkOutput("row_data", 64'(row_data), 64'(expRow));
            checkOutput("row_idx", 64'(row_idx), 64'(r3));
            rowSnap[r] = row_data;
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      note_addr = '0;
      repeat (2) @(negedge clk);
      checkAllZero("reset");
      reset = 1'b0;

      repeat (4) begin
         @(negedge clk);
         checkOutput("idle.rom_addr", 64'(rom_addr), 64'd0);
         checkOutput("idle.busy", 64'(busy), 64'd0);
         checkOutput("idle.row_valid", 64'(row_valid), 64'd0);
      end

      applyStimulus(WordA, 1'b0);
      @(negedge clk);
      checkOutput("A.busy_after_done", 64'(busy), 64'd0);
      checkOutput("A.done_after", 64'(done), 64'd0);
      checkOutput("A.row0", 64'(rowSnap[0]), 64'h90_28_98_A0_00);
      checkOutput("A.row3", 64'(rowSnap[3]), 64'h93_2B_9B_A3_03);
      checkOutput("A.addr_row3", 64'(addrSnap[3]), 64'd147);
      repeat (3) begin
         @(negedge clk);
         checkOutput("hold.row_data", 64'(row_data), 64'h97_2F_9F_A7_07);
         checkOutput("hold.row_idx", 64'(row_idx), 64'd7);
         checkOutput("hold.rom_addr", 64'(rom_addr), 64'd0);
         checkOutput("hold.busy", 64'(busy), 64'd0);
      end

      applyStimulus(WordD, 1'b0);
      @(negedge clk);
      checkOutput("D.busy_after_done", 64'(busy), 64'd0);
      checkOutput("D.addr_row2", 64'(addrSnap[2]), 64'h18A);

      // start held high throughout, with note_addr scrambled after acceptance
      applyStimulus(WordB, 1'b1);
      @(negedge clk);
      note_addr = WordA;
      checkOutput("B.busy_c57", 64'(busy), 64'd0);
      checkOutput("B.done_c57", 64'(done), 64'd0);
      @(negedge clk);
      checkOutput("B.restart_busy", 64'(busy), 64'd1);
      checkOutput("B.restart_addr", 64'(rom_addr), 64'd144);
      start = 1'b0;
      reset = 1'b1;
      #1;
      checkAllZero("B.reset");
      @(negedge clk);
      reset = 1'b0;

      // abandon a render at cycle 20
      @(negedge clk);
      start     = 1'b1;
      note_addr = WordA;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checkOutput("abort.busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      #1;
      checkAllZero("abort.reset");
      repeat (2) begin
         @(negedge clk);
         checkAllZero("abort.held");
      end
      reset = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checkAllZero("abort.after");
      end

      applyStimulus(WordA, 1'b0);
      @(negedge clk);
      checkOutput("final.busy", 64'(busy), 64'd0);
      checkOutput("final.row_idx", 64'(row_idx), 64'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/note_glyph_reader.md
NOTE_GLYPH_READER -- requirements
Module: note_glyph_reader

Interface
REQ-001 Parameter NUM_CHARS, default 5: number of 9-bit character-address fields in one note-address word.
REQ-002 Parameter GLYPH_ROWS, default 8: pixel rows per glyph; fixed at 8, matching the 3-bit row field of the font ROM address.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to render one note-address word; sampled only in IDLE.
REQ-006 note_addr  input  9*NUM_CHARS  packed character addresses (char index << 3); field 0 in bits [9*NUM_CHARS-1 -: 9], leftmost on screen.
REQ-007 rom_addr  output  9  font ROM address, {char index, row}.
REQ-008 rom_data  input  8  font ROM glyph row, valid 1 cycle after rom_addr (synchronous ROM).
REQ-009 row_data  output  8*NUM_CHARS  assembled pixel row; char 0 glyph in MSB byte.
REQ-010 row_idx  output  3  glyph row number of the current row_data.
REQ-011 row_valid  output  1  one-cycle pulse: row_data/row_idx hold a new complete row.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle pulse coincident with row_valid for row 7.

Function
REQ-014 States: IDLE, ISSUE, LAST, EMIT; registered state, one-hot or binary at implementer's choice.
REQ-015 IDLE: start=1 latches note_addr into an internal word register, clears char and row counters, enters ISSUE.
REQ-016 start SHALL be ignored in every state other than IDLE; note_addr changes after acceptance SHALL NOT affect the render.
REQ-017 ISSUE: rom_addr = {latched field[char][8:3], row[2:0]}; low 3 bits of each field ignored; char increments 0..NUM_CHARS-1, one per cycle.
REQ-018 ISSUE with char = NUM_CHARS-1 transitions to LAST; otherwise stays in ISSUE.
REQ-019 rom_data sampled in the cycle after char k is issued SHALL be written into assembly-buffer byte k (ISSUE captures chars 0..NUM_CHARS-2, LAST captures char NUM_CHARS-1).
REQ-020 LAST -> EMIT unconditionally; the complete assembly buffer loads into row_data and row into row_idx on that transition.
REQ-021 EMIT: row_valid=1 for exactly one cycle; if row=7, done=1 and next state IDLE; else row increments, char clears, next state ISSUE.
REQ-022 row_data and row_idx SHALL hold their values between EMIT loads and after returning to IDLE.
REQ-023 rom_addr SHALL be 0 in IDLE, LAST and EMIT.
REQ-024 Latency: start accepted at edge E0; first rom_addr in cycle after E0; each row takes NUM_CHARS+2 cycles; row_valid for row r in cycle 7(r+1) after E0 (default params); done in cycle 56.
REQ-025 start asserted in the same cycle as done (state EMIT) SHALL be ignored; a start in the following IDLE cycle is accepted.
REQ-026 Blank fields (index 32, address 256) SHALL be read from ROM like any other character; no skipping.

Reset
REQ-027 reset=1 SHALL immediately force state IDLE, rom_addr=0, row_data=0, row_idx=0, row_valid=0, done=0, busy=0, and clear counters and word/assembly registers.
REQ-028 reset asserted mid-render SHALL abandon the render with no row_valid or done pulse; a new start after reset release renders from row 0.

Verification
REQ-029 ROM model returns registered rom_addr[7:0]; start with word {144,40,152,160,256} -> row 0 rom_addr sequence 144,40,152,160,256; row_valid at cycle 7 with row_data=40'h90_28_98_A0_00, row_idx=0.
REQ-030 Same word, row 3 -> rom_addr 147,43,155,163,259; row_data=40'h93_2B_9B_A3_03, row_idx=3; done pulse exactly once at cycle 56 with row_idx=7, busy falls the next cycle.
REQ-031 start held high continuously with note_addr changing every cycle -> only the first word rendered; next render begins cycle 57, i.e. start sampled in first IDLE cycle after done.
REQ-032 Field with nonzero low bits (e.g. 9'h18F) -> rom_addr for row 2 equals 9'h18A.
REQ-033 reset pulsed at cycle 20 of a render -> all outputs 0 during and after reset, no done; subsequent start yields a full 8-row render with row_idx 0..7 in order.
REQ-034 Idle checks: no start -> rom_addr=0, busy=0, row_valid=0 indefinitely; row_data retains last rendered row.
